// File: rtl/seg_display_ctrl_pkg.sv
// Shared constants for the 7-segment display controller: segment patterns, FSM encodings, scan slots.
// Also holds the double-dabble nibble correction used by the converter.
package seg_display_ctrl_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CONV = 1'b1;

    localparam logic [1:0] IDX_ONES  = 2'd0;
    localparam logic [1:0] IDX_TENS  = 2'd1;
    localparam logic [1:0] IDX_HUNDS = 2'd2;
    localparam logic [1:0] IDX_SPARE = 2'd3;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/seg_display_ctrl_seg7_decode.sv
// BCD nibble to active-low {g,f,e,d,c,b,a} pattern; purely combinational, no flow control.
// Non-decimal nibbles render as a blank digit.
module seg7_decode
    import seg_display_ctrl_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_display_ctrl.sv
// Latches an 8-bit value, converts to BCD in 8 clocks (busy), and scans it onto a 4-digit display.
// Requests arriving while busy are dropped; display outputs lag the scan index by one clock.
module seg_display_ctrl
    import seg_display_ctrl_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] datainseg,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       busy
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [0:0]    state;
    logic [19:0]   shreg;
    logic [2:0]    bitcnt;
    logic [3:0]    hund, tens, ones;
    logic          disp_vld;
    logic [PW-1:0] presc;
    logic [1:0]    idx;

    logic [19:0]   adj;
    logic [19:0]   shifted;
    logic [3:0]    digit;
    logic          blank;
    logic [6:0]    dec_seg;

    always_comb begin
        adj     = {add3(shreg[19:16]), add3(shreg[15:12]), add3(shreg[11:8]), shreg[7:0]};
        shifted = {adj[18:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bitcnt   <= '0;
            hund     <= '0;
            tens     <= '0;
            ones     <= '0;
            disp_vld <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (datainseg[8]) begin
                shreg  <= {12'b0, datainseg[7:0]};
                bitcnt <= '0;
                state  <= ST_CONV;
            end
        end else begin
            shreg  <= shifted;
            bitcnt <= bitcnt + 3'd1;
            // Eighth shift: the BCD digits are complete in the shifted value
            if (bitcnt == 3'd7) begin
                hund     <= shifted[19:16];
                tens     <= shifted[15:12];
                ones     <= shifted[11:8];
                disp_vld <= 1'b1;
                state    <= ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PW'(REFRESH_DIV - 1)) begin
            presc <= '0;
            idx   <= idx + 2'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    always_comb begin
        digit = ones;
        blank = 1'b0;
        case (idx)
            IDX_ONES:  digit = ones;
            IDX_TENS: begin
                digit = tens;
                blank = BLANK_LZ && (hund == 4'd0) && (tens == 4'd0);
            end
            IDX_HUNDS: begin
                digit = hund;
                blank = BLANK_LZ && (hund == 4'd0);
            end
            default:   blank = 1'b1;
        endcase
    end

    seg7_decode u_dec (
        .bcd (digit),
        .seg (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (rst || !disp_vld) begin
            an  <= 4'hF;
            seg <= SEG_BLANK;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= blank ? SEG_BLANK : dec_seg;
        end
    end

    assign dp   = 1'b1;
    assign busy = (state == ST_CONV);

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench: two instances (leading-zero blanking on/off) share stimulus, REFRESH_DIV=4.
module tb_seg_display_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] datainseg;
    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b;
    logic [3:0] an_a, an_b;
    logic       busy_a, busy_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seg_display_ctrl #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .datainseg(datainseg),
        .seg(seg_a), .dp(dp_a), .an(an_a), .busy(busy_a)
    );

    seg_display_ctrl #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .datainseg(datainseg),
        .seg(seg_b), .dp(dp_b), .an(an_b), .busy(busy_b)
    );

    localparam logic [6:0] P0 = 7'b1000000;
    localparam logic [6:0] P1 = 7'b1111001;
    localparam logic [6:0] P2 = 7'b0100100;
    localparam logic [6:0] P4 = 7'b0011001;
    localparam logic [6:0] P5 = 7'b0010010;
    localparam logic [6:0] P7 = 7'b1111000;
    localparam logic [6:0] PB = 7'h7F;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy_a !== 1'b0 && n < 20) begin
            step(1);
            n++;
        end
        chk(tag, {31'd0, busy_a}, 32'd0);
    endtask

    // Finds the ones slot, then walks one slot per 4 clocks checking anode and pattern.
    task automatic check_digits(input string tag, input bit nb,
                                input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2);
        int n = 0;
        step(1);
        while ((nb ? an_b : an_a) !== 4'hE && n < 20) begin
            step(1);
            n++;
        end
        chk({tag, "_an0"}, nb ? an_b : an_a, 4'hE);
        chk({tag, "_seg0"}, nb ? seg_b : seg_a, s0);
        step(4);
        chk({tag, "_an1"}, nb ? an_b : an_a, 4'hD);
        chk({tag, "_seg1"}, nb ? seg_b : seg_a, s1);
        step(4);
        chk({tag, "_an2"}, nb ? an_b : an_a, 4'hB);
        chk({tag, "_seg2"}, nb ? seg_b : seg_a, s2);
        step(4);
        chk({tag, "_an3"}, nb ? an_b : an_a, 4'h7);
        chk({tag, "_seg3"}, nb ? seg_b : seg_a, PB);
    endtask

    task automatic request(input logic [8:0] v);
        datainseg = v;
        step(1);
        datainseg = 9'h000;
    endtask

    logic [6:0] exp_seg;

    initial begin
        rst = 1'b1;
        datainseg = 9'h000;
        step(2);
        rst = 1'b0;

        // 1: idle after reset, display stays blank
        for (int i = 0; i < 12; i++) begin
            chk("rst_an", an_a, 4'hF);
            chk("rst_seg", seg_a, PB);
            chk("rst_dp", dp_a, 1'b1);
            chk("rst_busy", busy_a, 1'b0);
            step(1);
        end

        // 2: 255, busy exactly 8 cycles
        request(9'h1FF);
        for (int i = 0; i < 8; i++) begin
            chk("busy_hi", busy_a, 1'b1);
            step(1);
        end
        chk("busy_lo", busy_a, 1'b0);
        check_digits("d255", 1'b0, P5, P5, P2);
        chk("dp255", dp_a, 1'b1);

        // 3: 7, with and without leading-zero blanking
        request(9'h107);
        wait_idle("idle7");
        check_digits("d7_lz", 1'b0, P7, PB, PB);
        check_digits("d7_nolz", 1'b1, P7, P0, P0);

        // 4: zero and 100
        request(9'h100);
        wait_idle("idle0");
        check_digits("d0", 1'b0, P0, PB, PB);
        request(9'h164);
        wait_idle("idle100");
        check_digits("d100", 1'b0, P0, P0, P1);

        // 5: mid-conversion change is ignored, held level reconverts next idle cycle
        datainseg = 9'h12A;
        step(3);
        datainseg = 9'h1C8;
        step(6);
        chk("e8_idle", busy_a, 1'b0);
        step(1);
        chk("reconv_busy", busy_a, 1'b1);
        datainseg = 9'h000;
        for (int i = 0; i < 7; i++) begin
            case (an_a)
                4'hE:    exp_seg = P2;
                4'hD:    exp_seg = P4;
                default: exp_seg = PB;
            endcase
            chk("d42_seg", seg_a, exp_seg);
            chk("d42_an_valid", (an_a == 4'hE || an_a == 4'hD || an_a == 4'hB || an_a == 4'h7), 1'b1);
            step(1);
        end
        wait_idle("idle200");
        check_digits("d200", 1'b0, P0, P0, P2);

        // 6: reset aborts a conversion and clears the display
        request(9'h1FF);
        wait_idle("idle255b");
        datainseg = 9'h10C;
        step(1);
        chk("abort_busy_pre", busy_a, 1'b1);
        step(3);
        rst = 1'b1;
        step(1);
        chk("abort_busy", busy_a, 1'b0);
        chk("abort_an", an_a, 4'hF);
        chk("abort_seg", seg_a, PB);
        rst = 1'b0;
        datainseg = 9'h000;
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("post_an", an_a, 4'hF);
            chk("post_seg", seg_a, PB);
            chk("post_busy", busy_a, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
